axi_lite_mem_arbiter: RTL and testbench



---
 rtl/axi_lite_mem_arbiter.sv | 172 +++++++++++++++++
 tb/tb_axi_lite_mem_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_mem_arbiter.sv
// Two-master (IFU read, LSU read/write) to one-slave AXI-lite arbiter.
// Serialises one transaction at a time and holds the request stable until it completes.
module axi_lite_mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned DATA_W     = 64
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [ADDR_W-1:0] if_araddr,
  input  logic              if_arvalid,
  output logic              if_arready,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_rvalid,
  input  logic              if_rready,
  input  logic [ADDR_W-1:0] ls_araddr,
  input  logic              ls_arvalid,
  output logic              ls_arready,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              ls_rvalid,
  input  logic              ls_rready,
  input  logic [ADDR_W-1:0] ls_waddr,
  input  logic [DATA_W-1:0] ls_wdata,
  input  logic [7:0]        ls_w_shifter,
  input  logic [7:0]        ls_w_DWHB,
  input  logic              ls_wvalid,
  output logic              ls_wready,
  output logic              ls_bvalid,
  input  logic              ls_bready,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic              rvalid,
  output logic              rready,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic [7:0]        w_shifter,
  output logic [7:0]        w_DWHB,
  output logic              wvalid,
  input  logic              wready,
  input  logic              bvalid,
  output logic              bready
);

  localparam int unsigned CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  typedef enum logic [2:0] {IDLE, IF_AR, IF_R, LS_AR, LS_R, LS_W, LS_B} state_t;
  typedef enum logic [1:0] {GNT_NONE, GNT_IF, GNT_LSR, GNT_LSW} grant_t;

  state_t           state, state_nxt;
  grant_t           grant;
  logic [CNT_W-1:0] starve_cnt, starve_nxt;

  // A starved IFU outranks even an LSU write; otherwise write > LSU read > IFU.
  always_comb begin
    grant = GNT_NONE;
    if (state == IDLE) begin
      if (if_arvalid && (starve_cnt == CNT_MAX)) grant = GNT_IF;
      else if (ls_wvalid)                        grant = GNT_LSW;
      else if (ls_arvalid)                       grant = GNT_LSR;
      else if (if_arvalid)                       grant = GNT_IF;
    end
  end

  always_comb begin
    starve_nxt = starve_cnt;
    if (state == IDLE) begin
      if (!if_arvalid || (grant == GNT_IF)) begin
        starve_nxt = '0;
      end else if (((grant == GNT_LSR) || (grant == GNT_LSW)) && (starve_cnt != CNT_MAX)) begin
        starve_nxt = starve_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      araddr    <= '0;
      waddr     <= '0;
      wdata     <= '0;
      w_shifter <= '0;
      w_DWHB    <= '0;
    end else begin
      case (grant)
        GNT_IF:  araddr <= if_araddr;
        GNT_LSR: araddr <= ls_araddr;
        GNT_LSW: begin
          waddr     <= ls_waddr;
          wdata     <= ls_wdata;
          w_shifter <= ls_w_shifter;
          w_DWHB    <= ls_w_DWHB;
        end
        default: ;
      endcase
    end
  end

  // Handshake outputs are forced low while rstn is asserted, not just after the state clears.
  always_comb begin
    state_nxt  = state;
    if_arready = 1'b0;
    ls_arready = 1'b0;
    ls_wready  = 1'b0;
    if_rvalid  = 1'b0;
    ls_rvalid  = 1'b0;
    if_rdata   = '0;
    ls_rdata   = '0;
    ls_bvalid  = 1'b0;
    arvalid    = 1'b0;
    rready     = 1'b0;
    wvalid     = 1'b0;
    bready     = 1'b0;
    case (state)
      IDLE: begin
        case (grant)
          GNT_IF:  state_nxt = IF_AR;
          GNT_LSR: state_nxt = LS_AR;
          GNT_LSW: state_nxt = LS_W;
          default: ;
        endcase
        if (rstn) begin
          if_arready = (grant == GNT_IF);
          ls_arready = (grant == GNT_LSR);
          ls_wready  = (grant == GNT_LSW);
        end
      end
      IF_AR: begin
        arvalid = rstn;
        if (arready) state_nxt = IF_R;
      end
      IF_R: begin
        if_rvalid = rstn && rvalid;
        if_rdata  = rdata;
        rready    = rstn && if_rready;
        if (rvalid && if_rready) state_nxt = IDLE;
      end
      LS_AR: begin
        arvalid = rstn;
        if (arready) state_nxt = LS_R;
      end
      LS_R: begin
        ls_rvalid = rstn && rvalid;
        ls_rdata  = rdata;
        rready    = rstn && ls_rready;
        if (rvalid && ls_rready) state_nxt = IDLE;
      end
      LS_W: begin
        wvalid = rstn;
        if (wready) state_nxt = LS_B;
      end
      LS_B: begin
        ls_bvalid = rstn && bvalid;
        bready    = rstn && ls_bready;
        if (bvalid && ls_bready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_lite_mem_arbiter.sv
// Self-checking bench: request queues per master, a bridge model, and a grant-order scoreboard.
module tb_axi_lite_mem_arbiter;

  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;

  typedef enum logic [1:0] {OWN_IF, OWN_LSR, OWN_LSW} owner_e;
  typedef struct {
    owner_e        owner;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [7:0]    sh;
    logic [7:0]    dw;
  } sb_t;
  typedef struct {
    bit          ifv;
    bit          lrv;
    bit          lwv;
    int unsigned ar_delay;
    int unsigned n;
    owner_e      o0;
    owner_e      o1;
    owner_e      o2;
  } vec_t;

  logic          clk = 1'b0;
  logic          rstn;
  logic [AW-1:0] if_araddr, ls_araddr, ls_waddr, araddr, waddr;
  logic [DW-1:0] if_rdata, ls_rdata, ls_wdata, rdata, wdata;
  logic [7:0]    ls_w_shifter, ls_w_DWHB, w_shifter, w_DWHB;
  logic          if_arvalid, if_arready, if_rvalid, if_rready;
  logic          ls_arvalid, ls_arready, ls_rvalid, ls_rready;
  logic          ls_wvalid, ls_wready, ls_bvalid, ls_bready;
  logic          arvalid, arready, rvalid, rready, wvalid, wready, bvalid, bready;

  axi_lite_mem_arbiter #(.STARVE_MAX(4), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rstn(rstn),
    .if_araddr(if_araddr), .if_arvalid(if_arvalid), .if_arready(if_arready),
    .if_rdata(if_rdata), .if_rvalid(if_rvalid), .if_rready(if_rready),
    .ls_araddr(ls_araddr), .ls_arvalid(ls_arvalid), .ls_arready(ls_arready),
    .ls_rdata(ls_rdata), .ls_rvalid(ls_rvalid), .ls_rready(ls_rready),
    .ls_waddr(ls_waddr), .ls_wdata(ls_wdata), .ls_w_shifter(ls_w_shifter),
    .ls_w_DWHB(ls_w_DWHB), .ls_wvalid(ls_wvalid), .ls_wready(ls_wready),
    .ls_bvalid(ls_bvalid), .ls_bready(ls_bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .waddr(waddr), .wdata(wdata), .w_shifter(w_shifter), .w_DWHB(w_DWHB),
    .wvalid(wvalid), .wready(wready), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  logic [AW-1:0] if_q[$];
  logic [AW-1:0] lr_q[$];
  sb_t           lw_q[$];
  sb_t           exp_q[$];
  logic [DW-1:0] bq[$];
  sb_t           cur;
  bit            cur_active = 1'b0;
  int unsigned   checks = 0;
  int unsigned   errors = 0;
  int unsigned   ar_delay = 0;
  int unsigned   ar_cnt = 0;
  bit            acc_if, acc_lr, acc_lw, hs_ar, hs_r, hs_w, hs_b, s_arvalid, s_wvalid;
  vec_t          vt[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input sb_t e);
    exp_q.push_back(e);
    if (e.owner != OWN_LSW) bq.push_back(e.data);
  endtask

  task automatic drain(input string tag, input int unsigned budget);
    int unsigned n;
    n = 0;
    while ((exp_q.size() != 0 || cur_active || if_q.size() != 0 || lr_q.size() != 0 ||
            lw_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL drain_%s: timed out after %0d cycles, %0d grants outstanding", tag, n, exp_q.size());
      exp_q.delete(); bq.delete(); if_q.delete(); lr_q.delete(); lw_q.delete();
      cur_active = 1'b0;
    end
    @(negedge clk);
  endtask

  // Monitor: samples away from the active edge and checks against the scoreboard.
  always @(negedge clk) begin
    owner_e      got;
    int unsigned nrdy;
    if (rstn) begin
      if (if_arready || ls_arready || ls_wready) begin
        got  = if_arready ? OWN_IF : (ls_arready ? OWN_LSR : OWN_LSW);
        nrdy = int'(if_arready) + int'(ls_arready) + int'(ls_wready);
        if (exp_q.size() == 0 || cur_active) begin
          checks++;
          errors++;
          $display("FAIL grant_unexpected: got owner %0d expected no grant at %0t", got, $time);
        end else begin
          cur        = exp_q.pop_front();
          cur_active = 1'b1;
          chk("grant_owner", 64'(got), 64'(cur.owner));
          chk("grant_onehot", 64'(nrdy), 64'd1);
        end
      end
      if (arvalid || wvalid) chk("ar_w_exclusive", 64'(arvalid && wvalid), 64'd0);
      if (arvalid && cur_active) begin
        chk("ar_owner_is_read", 64'(cur.owner != OWN_LSW), 64'd1);
        chk("araddr", araddr, cur.addr);
      end
      if (wvalid && cur_active) begin
        chk("w_owner_is_lsw", 64'(cur.owner == OWN_LSW), 64'd1);
        chk("waddr", waddr, cur.addr);
        chk("wdata", wdata, cur.data);
        chk("w_shifter", 64'(w_shifter), 64'(cur.sh));
        chk("w_DWHB", 64'(w_DWHB), 64'(cur.dw));
      end
      if (rvalid && cur_active && cur.owner != OWN_LSW) begin
        chk("if_rvalid", 64'(if_rvalid), 64'(cur.owner == OWN_IF));
        chk("ls_rvalid", 64'(ls_rvalid), 64'(cur.owner == OWN_LSR));
        chk("rready", 64'(rready), 64'((cur.owner == OWN_IF) ? if_rready : ls_rready));
        chk("rdata", (cur.owner == OWN_IF) ? if_rdata : ls_rdata, cur.data);
      end
      if (bvalid && cur_active && cur.owner == OWN_LSW) begin
        chk("ls_bvalid", 64'(ls_bvalid), 64'd1);
        chk("bready", 64'(bready), 64'(ls_bready));
      end
      if ((rvalid && rready) || (bvalid && bready)) cur_active = 1'b0;
    end
    acc_if    = if_arready;
    acc_lr    = ls_arready;
    acc_lw    = ls_wready;
    hs_ar     = arvalid && arready;
    hs_r      = rvalid && rready;
    hs_w      = wvalid && wready;
    hs_b      = bvalid && bready;
    s_arvalid = arvalid;
    s_wvalid  = wvalid;
  end

  // Masters: present the queue head until the arbiter accepts it.
  initial forever begin
    @(posedge clk); #1;
    if (acc_if && if_q.size() != 0) void'(if_q.pop_front());
    if (acc_lr && lr_q.size() != 0) void'(lr_q.pop_front());
    if (acc_lw && lw_q.size() != 0) void'(lw_q.pop_front());
    if_arvalid   = (if_q.size() != 0);
    if_araddr    = if_arvalid ? if_q[0] : '0;
    ls_arvalid   = (lr_q.size() != 0);
    ls_araddr    = ls_arvalid ? lr_q[0] : '0;
    ls_wvalid    = (lw_q.size() != 0);
    ls_waddr     = ls_wvalid ? lw_q[0].addr : '0;
    ls_wdata     = ls_wvalid ? lw_q[0].data : '0;
    ls_w_shifter = ls_wvalid ? lw_q[0].sh : '0;
    ls_w_DWHB    = ls_wvalid ? lw_q[0].dw : '0;
  end

  // Bridge: arready after ar_delay cycles, read data from bq, single-cycle wready.
  initial forever begin
    @(posedge clk); #1;
    if (!rstn) begin
      arready = 1'b0; rvalid = 1'b0; rdata = '0; wready = 1'b0; bvalid = 1'b0; ar_cnt = 0;
    end else begin
      if (hs_ar) begin
        arready = 1'b0;
        ar_cnt  = 0;
        rvalid  = 1'b1;
        rdata   = (bq.size() != 0) ? bq.pop_front() : '0;
      end else if (s_arvalid && !arready) begin
        if (ar_cnt >= ar_delay) arready = 1'b1;
        else ar_cnt++;
      end
      if (hs_r) begin
        rvalid = 1'b0;
        rdata  = '0;
      end
      if (hs_w) begin
        wready = 1'b0;
        bvalid = 1'b1;
      end else if (s_wvalid && !wready) begin
        wready = 1'b1;
      end
      if (hs_b) bvalid = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1);
  end

  initial begin
    sb_t         e, e_if, e_lr, e_lw;
    owner_e      o;
    int unsigned n;
    int unsigned li, ii;

    vt[0] = '{1'b1, 1'b0, 1'b0, 2, 1, OWN_IF,  OWN_IF,  OWN_IF};
    vt[1] = '{1'b0, 1'b1, 1'b0, 0, 1, OWN_LSR, OWN_LSR, OWN_LSR};
    vt[2] = '{1'b0, 1'b0, 1'b1, 0, 1, OWN_LSW, OWN_LSW, OWN_LSW};
    vt[3] = '{1'b1, 1'b1, 1'b0, 1, 2, OWN_LSR, OWN_IF,  OWN_IF};
    vt[4] = '{1'b0, 1'b1, 1'b1, 0, 2, OWN_LSW, OWN_LSR, OWN_LSR};
    vt[5] = '{1'b1, 1'b0, 1'b1, 0, 2, OWN_LSW, OWN_IF,  OWN_IF};
    vt[6] = '{1'b1, 1'b1, 1'b1, 3, 3, OWN_LSW, OWN_LSR, OWN_IF};

    rstn = 1'b0;
    if_rready = 1'b1; ls_rready = 1'b1; ls_bready = 1'b1;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; wready = 1'b0; bvalid = 1'b0;
    if_arvalid = 1'b0; if_araddr = '0; ls_arvalid = 1'b0; ls_araddr = '0;
    ls_wvalid = 1'b0; ls_waddr = '0; ls_wdata = '0; ls_w_shifter = '0; ls_w_DWHB = '0;

    // Reset with an IFU request already pending: nothing may be accepted until release.
    e = '{OWN_IF, 64'h0000_0000_0000_1000, 64'h0badc0de_00000001, 8'h00, 8'h00};
    if_q.push_back(e.addr);
    push_exp(e);
    repeat (3) @(negedge clk);
    chk("rst_if_arvalid_driven", 64'(if_arvalid), 64'd1);
    chk("rst_if_arready", 64'(if_arready), 64'd0);
    chk("rst_ls_arready", 64'(ls_arready), 64'd0);
    chk("rst_ls_wready", 64'(ls_wready), 64'd0);
    chk("rst_arvalid", 64'(arvalid), 64'd0);
    chk("rst_wvalid", 64'(wvalid), 64'd0);
    chk("rst_araddr", araddr, 64'd0);
    chk("rst_waddr", waddr, 64'd0);
    chk("rst_wdata", wdata, 64'd0);
    chk("rst_w_masks", 64'({w_shifter, w_DWHB}), 64'd0);
    @(posedge clk); #3;
    rstn = 1'b1;
    @(negedge clk);
    chk("post_rst_if_arready", 64'(if_arready), 64'd1);
    drain("reset_release", 100);

    for (int unsigned i = 0; i < 7; i++) begin
      e_if = '{OWN_IF,  64'h8000_0000 + 64'(i) * 64'h40, {$urandom, $urandom}, 8'h00, 8'h00};
      e_lr = '{OWN_LSR, 64'h1000_0000 + 64'(i) * 64'h8, {$urandom, $urandom}, 8'h00, 8'h00};
      e_lw = '{OWN_LSW, 64'h4000_0000 + 64'(i) * 64'h10, {$urandom, $urandom},
               8'(i), 8'(i + 1)};
      if (i == 0) e_if.data = 64'h1122334455667788;
      ar_delay = vt[i].ar_delay;
      if (vt[i].ifv) if_q.push_back(e_if.addr);
      if (vt[i].lrv) lr_q.push_back(e_lr.addr);
      if (vt[i].lwv) lw_q.push_back(e_lw);
      for (int unsigned k = 0; k < vt[i].n; k++) begin
        o = (k == 0) ? vt[i].o0 : ((k == 1) ? vt[i].o1 : vt[i].o2);
        case (o)
          OWN_IF:  push_exp(e_if);
          OWN_LSR: push_exp(e_lr);
          default: push_exp(e_lw);
        endcase
      end
      drain("vector", 100);
    end

    // Starvation: four LSU grants, then the IFU; the counter must restart from zero.
    ar_delay = 0;
    for (int unsigned k = 0; k < 2; k++) if_q.push_back(64'h8000_1000 + 64'(k) * 64'h8);
    for (int unsigned k = 0; k < 9; k++) lr_q.push_back(64'h2000_0000 + 64'(k) * 64'h8);
    li = 0;
    ii = 0;
    for (int unsigned k = 0; k < 11; k++) begin
      if (k == 4 || k == 9) begin
        e = '{OWN_IF, 64'h8000_1000 + 64'(ii) * 64'h8, {$urandom, $urandom}, 8'h00, 8'h00};
        ii++;
      end else begin
        e = '{OWN_LSR, 64'h2000_0000 + 64'(li) * 64'h8, {$urandom, $urandom}, 8'h00, 8'h00};
        li++;
      end
      push_exp(e);
    end
    drain("starve", 400);

    // Write with response back-pressure; a pending IFU read must wait in LS_B.
    ls_bready = 1'b0;
    e = '{OWN_LSW, 64'ha000_03f8, 64'h0000_0000_dead_beef, 8'h03, 8'h02};
    lw_q.push_back(e);
    push_exp(e);
    e = '{OWN_IF, 64'h8000_2000, 64'hcafe_f00d_1234_5678, 8'h00, 8'h00};
    if_q.push_back(e.addr);
    push_exp(e);
    n = 0;
    while (!ls_bvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("wait_ls_bvalid", 64'(ls_bvalid), 64'd1);
    repeat (3) begin
      @(negedge clk);
      chk("hold_ls_bvalid", 64'(ls_bvalid), 64'd1);
      chk("hold_bready", 64'(bready), 64'd0);
      chk("hold_if_arready", 64'(if_arready), 64'd0);
    end
    @(posedge clk); #1;
    ls_bready = 1'b1;
    drain("write_bp", 100);

    // Asynchronous reset in the middle of an LSU read data phase.
    ls_rready = 1'b0;
    e = '{OWN_LSR, 64'h3000_0040, {$urandom, $urandom}, 8'h00, 8'h00};
    lr_q.push_back(e.addr);
    push_exp(e);
    n = 0;
    while (!ls_rvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("wait_ls_rvalid", 64'(ls_rvalid), 64'd1);
    @(posedge clk); #3;
    rstn = 1'b0;
    #1;
    chk("mid_rst_ls_rvalid", 64'(ls_rvalid), 64'd0);
    chk("mid_rst_rready", 64'(rready), 64'd0);
    chk("mid_rst_arvalid", 64'(arvalid), 64'd0);
    chk("mid_rst_wvalid", 64'(wvalid), 64'd0);
    chk("mid_rst_readies", 64'({if_arready, ls_arready, ls_wready, bready}), 64'd0);
    chk("mid_rst_araddr", araddr, 64'd0);
    exp_q.delete(); bq.delete(); if_q.delete(); lr_q.delete(); lw_q.delete();
    cur_active = 1'b0;
    ls_rready  = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk); #3;
    rstn = 1'b1;
    e = '{OWN_IF, 64'h8000_3000, {$urandom, $urandom}, 8'h00, 8'h00};
    if_q.push_back(e.addr);
    push_exp(e);
    @(posedge clk); #2;
    chk("after_mid_rst_if_arready", 64'(if_arready), 64'd1);
    drain("mid_reset", 100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
